// File: rtl/positadd_arbiter_4_pkg.sv
// Shared widths, FSM state and in-flight tag type for the posit adder arbiter.
package posit_defines;

    localparam int unsigned POSIT_SERIALIZED_WIDTH_ES2     = 16;
    localparam int unsigned POSIT_SERIALIZED_WIDTH_SUM_ES2 = 16;

    typedef enum logic {
        FLUSH,
        RUN
    } arb_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } tag_t;

endpackage

// File: rtl/positadd_arbiter_4_if.sv
// Requester, adder and result signals of the arbiter; slave is the arbiter's view.
interface positadd_arbiter_4_if #(
    parameter int unsigned NREQ = 4
);
    import posit_defines::*;

    logic [NREQ-1:0]                                     req_valid;
    logic [NREQ-1:0]                                     req_ready;
    logic [NREQ-1:0][POSIT_SERIALIZED_WIDTH_ES2-1:0]     req_in1;
    logic [NREQ-1:0][POSIT_SERIALIZED_WIDTH_ES2-1:0]     req_in2;
    logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]               add_in1;
    logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]               add_in2;
    logic                                                add_start;
    logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]           add_result;
    logic                                                add_done;
    logic                                                add_truncated;
    logic                                                res_valid;
    logic [1:0]                                          res_id;
    logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]           res_data;
    logic                                                res_truncated;
    logic                                                busy;
    logic                                                tag_error;

    modport slave (
        input  req_valid, req_in1, req_in2, add_result, add_done, add_truncated,
        output req_ready, add_in1, add_in2, add_start, res_valid, res_id, res_data,
               res_truncated, busy, tag_error
    );

    modport master (
        output req_valid, req_in1, req_in2, add_result, add_done, add_truncated,
        input  req_ready, add_in1, add_in2, add_start, res_valid, res_id, res_data,
               res_truncated, busy, tag_error
    );

endinterface

// File: rtl/positadd_arbiter_4_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, mod 4.
module rr_pick_4 (
    input  logic [1:0] ptr,
    input  logic [3:0] eligible,
    output logic [3:0] grant_onehot,
    output logic [1:0] grant_id
);

    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic       w_hit;
    logic [1:0] w_off;

    // Rotate so bit 0 is the requester at ptr; lowest set bit then wins.
    assign w_dbl = {eligible, eligible} >> ptr;
    assign w_rot = w_dbl[3:0];

    always_comb begin
        w_hit = 1'b0;
        w_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_hit = 1'b1;
                w_off = 2'(k);
            end
        end
    end

    assign grant_id     = ptr + w_off;
    assign grant_onehot = w_hit ? (4'b0001 << grant_id) : 4'b0000;

endmodule

// File: rtl/positadd_arbiter_4.sv
// Four-way round-robin front end for one shared, non-resettable posit adder,
// with per-requester credit limits and a tag pipeline that tracks adder latency.
module positadd_arbiter_4
    import posit_defines::*;
#(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned ADD_LATENCY     = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input logic                  clk,
    input logic                  reset,
    positadd_arbiter_4_if.slave  arb
);

    localparam int unsigned CNT_W = $clog2(ADD_LATENCY + 1);

    arb_state_t                                  r_state;
    logic [CNT_W-1:0]                            r_flush_cnt;
    logic [1:0]                                  r_rr_ptr;
    logic [NREQ-1:0][2:0]                        r_outstanding;
    tag_t                                        r_start_tag;
    tag_t [ADD_LATENCY-1:0]                      r_tag_sr;
    logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]       r_add_in1;
    logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]       r_add_in2;
    logic                                        r_res_valid;
    logic [1:0]                                  r_res_id;
    logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]   r_res_data;
    logic                                        r_res_truncated;
    logic                                        r_tag_error;

    logic       w_run;
    logic [3:0] w_eligible;
    logic [3:0] w_grant_onehot;
    logic [1:0] w_grant_id;
    logic       w_xfer;
    tag_t       w_tag_out;
    logic       w_result;

    assign w_run     = (r_state == RUN);
    assign w_tag_out = r_tag_sr[ADD_LATENCY-1];
    assign w_result  = w_run && arb.add_done && w_tag_out.valid;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_eligible[i] = w_run && arb.req_valid[i] &&
                            (r_outstanding[i] < 3'(MAX_OUTSTANDING));
        end
    end

    rr_pick_4 u_pick (
        .ptr          (r_rr_ptr),
        .eligible     (w_eligible),
        .grant_onehot (w_grant_onehot),
        .grant_id     (w_grant_id)
    );

    // Eligibility already includes req_valid, so any grant is a transfer.
    assign w_xfer = |w_grant_onehot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= FLUSH;
            r_flush_cnt     <= '0;
            r_rr_ptr        <= 2'd0;
            r_outstanding   <= '0;
            r_start_tag     <= '0;
            r_tag_sr        <= '0;
            r_add_in1       <= '0;
            r_add_in2       <= '0;
            r_res_valid     <= 1'b0;
            r_res_id        <= 2'd0;
            r_res_data      <= '0;
            r_res_truncated <= 1'b0;
            r_tag_error     <= 1'b0;
        end else begin
            case (r_state)
                FLUSH: begin
                    if (r_flush_cnt == CNT_W'(ADD_LATENCY - 1)) r_state <= RUN;
                    else r_flush_cnt <= r_flush_cnt + 1'b1;
                end
                RUN:     r_state <= RUN;
                default: r_state <= FLUSH;
            endcase

            r_start_tag.valid <= w_xfer;
            r_start_tag.id    <= w_grant_id;
            r_tag_sr          <= {r_tag_sr[ADD_LATENCY-2:0], r_start_tag};

            if (w_xfer) begin
                r_add_in1 <= arb.req_in1[w_grant_id];
                r_add_in2 <= arb.req_in2[w_grant_id];
                r_rr_ptr  <= w_grant_id + 2'd1;
            end

            r_res_valid <= w_result;
            if (w_run && arb.add_done) begin
                r_res_id        <= w_tag_out.id;
                r_res_data      <= arb.add_result;
                r_res_truncated <= arb.add_truncated;
            end
            if (w_run && (arb.add_done != w_tag_out.valid)) r_tag_error <= 1'b1;

            for (int i = 0; i < NREQ; i++) begin
                if ((w_xfer && w_grant_id == 2'(i)) && !(w_result && w_tag_out.id == 2'(i))) begin
                    r_outstanding[i] <= r_outstanding[i] + 3'd1;
                end else if (!(w_xfer && w_grant_id == 2'(i)) &&
                             (w_result && w_tag_out.id == 2'(i))) begin
                    r_outstanding[i] <= r_outstanding[i] - 3'd1;
                end
            end
        end
    end

    assign arb.req_ready     = w_grant_onehot;
    assign arb.add_in1       = r_add_in1;
    assign arb.add_in2       = r_add_in2;
    assign arb.add_start     = r_start_tag.valid;
    assign arb.res_valid     = r_res_valid;
    assign arb.res_id        = r_res_id;
    assign arb.res_data      = r_res_data;
    assign arb.res_truncated = r_res_truncated;
    assign arb.busy          = (r_state == FLUSH) || (|r_outstanding);
    assign arb.tag_error     = r_tag_error;

endmodule

// File: tb/tb_positadd_arbiter_4.sv
// Directed + random bench for positadd_arbiter_4 with a non-resettable adder model
// and a transaction-level reference model of grants, credits and result timing.
module tb_positadd_arbiter_4;
    import posit_defines::*;

    localparam int L    = 8;
    localparam int MAXO = 4;
    localparam int W    = POSIT_SERIALIZED_WIDTH_ES2;
    localparam int WS   = POSIT_SERIALIZED_WIDTH_SUM_ES2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_done = 1'b0;
    always #5 clk = ~clk;

    positadd_arbiter_4_if #(.NREQ(4)) bus ();

    positadd_arbiter_4 #(
        .NREQ            (4),
        .ADD_LATENCY     (L),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    // Stand-in adder: 1.0 + 1.0 gives posit 2.0, anything else a plain integer sum.
    function automatic logic [WS-1:0] f_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 16'h4000 && b == 16'h4000) return 16'h4800;
        return a + b;
    endfunction

    function automatic logic f_tr(input logic [W-1:0] a, input logic [W-1:0] b);
        return a[0] & b[0];
    endfunction

    // Adder pipeline has no reset, so operations survive a DUT reset.
    logic [L-1:0]  a_v = '0;
    logic [WS-1:0] a_d [L];
    logic          a_t [L];
    initial begin
        for (int k = 0; k < L; k++) begin
            a_d[k] = '0;
            a_t[k] = 1'b0;
        end
    end
    always @(posedge clk) begin
        a_v    <= {a_v[L-2:0], bus.add_start};
        a_d[0] <= f_sum(bus.add_in1, bus.add_in2);
        a_t[0] <= f_tr(bus.add_in1, bus.add_in2);
        for (int k = L - 1; k > 0; k--) begin
            a_d[k] <= a_d[k-1];
            a_t[k] <= a_t[k-1];
        end
    end
    assign bus.add_done      = a_v[L-1] | force_done;
    assign bus.add_result    = a_d[L-1];
    assign bus.add_truncated = a_t[L-1];

    typedef struct {
        int          id;
        int          done_cyc;
        logic [WS-1:0] data;
        logic        tr;
    } op_t;

    op_t         ops [$];
    int          cyc = 0;
    int          flush_left = L;
    int          rr = 0;
    int          out_cnt [4];
    bit          exp_start = 0;
    logic [W-1:0] exp_in1 = '0;
    logic [W-1:0] exp_in2 = '0;
    bit          m_tag_err = 0;
    logic [3:0]  obs_ready = '0;
    int          flush_done_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    int          grant_log [$];
    bit          log_grants = 0;
    int          r1_xfers;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check outputs at negedge, advance the model, return at posedge+1.
    task automatic step();
        logic [3:0] er;
        int         g;
        bit         in_flush;
        bit         exp_rv;
        bit         due;
        bit         exp_busy;
        op_t        rop;
        @(negedge clk);
        in_flush = (flush_left > 0);
        rop = '{0, 0, '0, 1'b0};
        if (reset) begin
            ops.delete();
            for (int i = 0; i < 4; i++) out_cnt[i] = 0;
            rr = 0;
            flush_left = L;
            m_tag_err = 0;
            exp_start = 0;
            exp_in1 = '0;
            exp_in2 = '0;
        end else begin
            er = '0;
            g  = -1;
            if (!in_flush) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (rr + k) % 4;
                    if (g < 0 && bus.req_valid[i] && out_cnt[i] < MAXO) g = i;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            obs_ready = bus.req_ready;
            if (log_grants) begin
                for (int i = 0; i < 4; i++) if (obs_ready[i]) grant_log.push_back(i);
                if (obs_ready == 4'b0) grant_log.push_back(-1);
            end
            chk("req_ready", 32'(bus.req_ready), 32'(er));

            exp_rv = 0;
            due    = 0;
            foreach (ops[j]) begin
                if (ops[j].done_cyc + 1 == cyc) begin
                    exp_rv = 1;
                    rop    = ops[j];
                end
                if (ops[j].done_cyc == cyc) due = 1;
            end
            chk("res_valid", 32'(bus.res_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("res_id", 32'(bus.res_id), 32'(rop.id));
                chk("res_data", 32'(bus.res_data), 32'(rop.data));
                chk("res_truncated", 32'(bus.res_truncated), 32'(rop.tr));
            end
            chk("add_start", 32'(bus.add_start), 32'(exp_start));
            chk("add_in1", 32'(bus.add_in1), 32'(exp_in1));
            chk("add_in2", 32'(bus.add_in2), 32'(exp_in2));
            exp_busy = in_flush;
            for (int i = 0; i < 4; i++) if (out_cnt[i] != 0) exp_busy = 1;
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("tag_error", 32'(bus.tag_error), 32'(m_tag_err));
            if (in_flush && bus.add_done) flush_done_cnt++;

            for (int j = ops.size() - 1; j >= 0; j--) begin
                if (ops[j].done_cyc == cyc) out_cnt[ops[j].id]--;
                if (ops[j].done_cyc + 1 == cyc) ops.delete(j);
            end
            if (!in_flush && force_done && !due) m_tag_err = 1;
            exp_start = (g >= 0);
            if (g >= 0) begin
                exp_in1 = bus.req_in1[g];
                exp_in2 = bus.req_in2[g];
                ops.push_back('{g, cyc + L + 1, f_sum(exp_in1, exp_in2), f_tr(exp_in1, exp_in2)});
                out_cnt[g]++;
                rr = (g + 1) % 4;
            end
            if (in_flush) flush_left--;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v);
        bus.req_valid = v;
        for (int i = 0; i < 4; i++) begin
            bus.req_in1[i] = 16'($urandom);
            bus.req_in2[i] = 16'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(4'b0000);
            step();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            drive(4'b0000);
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) out_cnt[i] = 0;
        drive(4'b0000);
        @(posedge clk);
        #1;
        do_reset(3);

        // All requesters hammer from the first cycle after reset.
        log_grants = 1;
        for (int k = 0; k < 20; k++) begin
            drive(4'b1111);
            step();
        end
        log_grants = 0;
        for (int k = 0; k < 8; k++) chk("flush_no_grant", 32'(grant_log[k]), 32'hFFFF_FFFF);
        for (int k = 8; k < 20; k++) chk("rr_order", 32'(grant_log[k]), 32'((k - 8) % 4));
        idle(14);

        // Requester 2 adds 1.0 + 1.0 in the first RUN cycle.
        do_reset(2);
        idle(8);
        drive(4'b0100);
        bus.req_in1[2] = 16'h4000;
        bus.req_in2[2] = 16'h4000;
        step();
        idle(14);

        // Requester 1 runs out of credits; 0 and 3 keep being served.
        r1_xfers = 0;
        for (int k = 0; k < 30; k++) begin
            drive(k >= 5 ? 4'b1011 : 4'b0010);
            step();
            if (k < 9 && obs_ready[1]) r1_xfers++;
        end
        chk("r1_credit_limit", 32'(r1_xfers), 32'd4);
        idle(16);

        for (int k = 0; k < 300; k++) begin
            drive(4'($urandom));
            step();
        end
        idle(16);

        // Reset three cycles after a transfer; its done must fall inside FLUSH.
        drive(4'b0001);
        step();
        idle(2);
        flush_done_cnt = 0;
        do_reset(1);
        idle(30);
        chk("stale_done_in_flush", 32'(flush_done_cnt), 32'd1);

        // Spurious done with no tag in flight.
        drive(4'b0000);
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        idle(6);
        chk("tag_error_sticky", 32'(bus.tag_error), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
